ps2_host_tx: RTL

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
//
// Ports:
//   clock, reset         system clock (rising edge), synchronous active-high reset
//   txData, txValid      command byte and request strobe
//   txReady              high only while idle; byte taken when txValid && txReady
//   ps2ClkIn, ps2DataIn  sensed PS/2 lines (asynchronous)
//   ps2ClkOe, ps2DataOe  1 = pull the line low, 0 = release (open-drain)
//   txDone               one-cycle pulse when the device acknowledged the byte
//   txError              one-cycle pulse on NACK or timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkOe,
  output logic       ps2DataOe,
  output logic       txDone,
  output logic       txError
);

  localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} stateT;

  stateT          state, stateNext;
  logic [1:0]     clkSync, dataSync;
  logic           clkPrev;
  logic [9:0]     frame, frameNext;
  logic [3:0]     bitCnt, bitCntNext;
  logic [CW-1:0]  cycleCnt, cycleCntNext;
  logic           clkOeNext, dataOeNext, doneNext, errorNext;
  logic           fallEdge, timeoutHit;

  // Edge detection uses the synchronized line only; falls are acted on
  // solely in SEND/ACK, so the inhibit pulse we drive ourselves is ignored.
  assign fallEdge   = clkPrev & ~clkSync[1];
  assign timeoutHit = (cycleCnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      clkSync  <= 2'b00;
      dataSync <= 2'b00;
      clkPrev  <= 1'b0;
    end else begin
      clkSync  <= {clkSync[0], ps2ClkIn};
      dataSync <= {dataSync[0], ps2DataIn};
      clkPrev  <= clkSync[1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      frame     <= '0;
      bitCnt    <= '0;
      cycleCnt  <= '0;
      ps2ClkOe  <= 1'b0;
      ps2DataOe <= 1'b0;
      txDone    <= 1'b0;
      txError   <= 1'b0;
      txReady   <= 1'b1;
    end else begin
      state     <= stateNext;
      frame     <= frameNext;
      bitCnt    <= bitCntNext;
      cycleCnt  <= cycleCntNext;
      ps2ClkOe  <= clkOeNext;
      ps2DataOe <= dataOeNext;
      txDone    <= doneNext;
      txError   <= errorNext;
      txReady   <= (stateNext == IDLE);
    end
  end

  always_comb begin
    stateNext    = state;
    frameNext    = frame;
    bitCntNext   = bitCnt;
    cycleCntNext = cycleCnt;
    clkOeNext    = 1'b0;
    dataOeNext   = 1'b0;
    doneNext     = 1'b0;
    errorNext    = 1'b0;
    case (state)
      IDLE: begin
        if (txValid) begin
          // Frame bits 0..9 go out LSB first: d0..d7, odd parity, stop.
          frameNext    = {1'b1, ~^txData, txData};
          bitCntNext   = '0;
          cycleCntNext = '0;
          clkOeNext    = 1'b1;
          stateNext    = INHIBIT;
        end
      end
      INHIBIT: begin
        clkOeNext = 1'b1;
        if (cycleCnt == CW'(INHIBIT_CYCLES - 1)) begin
          dataOeNext = 1'b1;
          stateNext  = REQ;
        end else begin
          cycleCntNext = cycleCnt + 1'b1;
        end
      end
      REQ: begin
        // Clock released, start bit (data low) held until the first device edge.
        dataOeNext   = 1'b1;
        cycleCntNext = '0;
        stateNext    = SEND;
      end
      SEND: begin
        dataOeNext = ps2DataOe;
        if (fallEdge) begin
          dataOeNext   = ~frame[bitCnt];
          bitCntNext   = bitCnt + 4'd1;
          cycleCntNext = '0;
          if (bitCnt == 4'd9) stateNext = ACK;
        end else if (timeoutHit) begin
          dataOeNext = 1'b0;
          errorNext  = 1'b1;
          stateNext  = IDLE;
        end else begin
          cycleCntNext = cycleCnt + 1'b1;
        end
      end
      ACK: begin
        if (fallEdge) begin
          bitCntNext   = bitCnt + 4'd1;
          cycleCntNext = '0;
          if (!dataSync[1]) begin
            stateNext = WAIT_IDLE;
          end else begin
            errorNext = 1'b1;
            stateNext = IDLE;
          end
        end else if (timeoutHit) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          cycleCntNext = cycleCnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clkSync[1] && dataSync[1]) begin
          doneNext  = 1'b1;
          stateNext = IDLE;
        end else if (timeoutHit) begin
          errorNext = 1'b1;
          stateNext = IDLE;
        end else begin
          cycleCntNext = cycleCnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule
